// File: rtl/led_chaser_module.sv
// led_chaser_module
//   Steps a light pattern across LED_NUM board LEDs on every rising edge of a
//   slow timing pulse, and counts completed pattern cycles for debug/display.
//
// Parameters
//   LED_NUM     number of LEDs driven (2..16)
//   CNT_W       width of the completed-cycle counter
//
// Ports
//   CLK         system clock (50 MHz)
//   RST         synchronous active-high reset, overrides every other input
//   PULSE_IN    step pulse from the LED timing generator, same clock domain
//   EN          1 = steps accepted, 0 = pattern frozen
//   MODE        00 rotate-left, 01 rotate-right, 10 ping-pong, 11 bar-fill
//   LED_OUT     registered LED drive, 1 = lit
//   CYCLE_DONE  one-cycle strobe on the edge that completes a pattern cycle
//   CYCLE_CNT   completed-cycle count, wraps at 2^CNT_W
module led_chaser_module #(
  parameter int unsigned LED_NUM = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PULSE_IN,
  input  logic               EN,
  input  logic [1:0]         MODE,
  output logic [LED_NUM-1:0] LED_OUT,
  output logic               CYCLE_DONE,
  output logic [CNT_W-1:0]   CYCLE_CNT
);

  // Bar-fill needs one extra position for the blank frame, so pos spans 0..LED_NUM.
  localparam int unsigned PosW = $clog2(LED_NUM + 1);

  localparam logic [PosW-1:0]    PosZero  = '0;
  localparam logic [PosW-1:0]    PosTop   = PosW'(LED_NUM - 1);
  localparam logic [PosW-1:0]    PosBlank = PosW'(LED_NUM);
  localparam logic [LED_NUM-1:0] LedReset = LED_NUM'(1);
  localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(1);

  typedef enum logic [1:0] {
    ModeRotL = 2'b00,
    ModeRotR = 2'b01,
    ModePing = 2'b10,
    ModeBar  = 2'b11
  } mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  // State
  logic               pulse_q;
  mode_e              mode_q;
  logic [PosW-1:0]    pos_q,  pos_d;
  dir_e               dir_q,  dir_d;
  logic [LED_NUM-1:0] led_q,  led_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;

  // Decoded controls
  logic mode_chg;
  logic step;
  logic wrap;

  assign mode_chg = (MODE != mode_q);
  // pulse_q tracks PULSE_IN even while EN is low, so a pulse that is already
  // high when EN rises is not seen as a fresh rising edge.
  assign step     = PULSE_IN & ~pulse_q & EN;

  // Position / direction next-state and cycle-completion detect.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    wrap  = 1'b0;

    if (mode_chg) begin
      // A mode change restarts the pattern and swallows any coincident step.
      pos_d = PosZero;
      dir_d = DirUp;
    end else if (step) begin
      unique case (mode_q)
        ModeRotL: begin
          if (pos_q == PosTop) begin
            pos_d = PosZero;
            wrap  = 1'b1;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end

        ModeRotR: begin
          if (pos_q == PosZero) begin
            pos_d = PosTop;
            wrap  = 1'b1;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end

        ModePing: begin
          // Direction flips on arrival at an end, so each end LED is shown once.
          if (dir_q == DirUp) begin
            pos_d = pos_q + 1'b1;
            if (pos_d == PosTop) begin
              dir_d = DirDown;
            end
          end else begin
            pos_d = pos_q - 1'b1;
            if (pos_d == PosZero) begin
              dir_d = DirUp;
              wrap  = 1'b1;
            end
          end
        end

        ModeBar: begin
          if (pos_q == PosBlank) begin
            pos_d = PosZero;
          end else begin
            pos_d = pos_q + 1'b1;
            if (pos_q == PosTop) begin
              wrap = 1'b1;
            end
          end
        end

        default: begin
          pos_d = pos_q;
        end
      endcase
    end
  end

  // LED decode from the next position. On a mode-change edge pos_d is zero,
  // which decodes to bit0 in every mode, so mode_q is safe to use here.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < int'(LED_NUM); i++) begin
      if (mode_q == ModeBar) begin
        led_d[i] = (pos_d != PosBlank) && (PosW'(i) <= pos_d);
      end else begin
        led_d[i] = (PosW'(i) == pos_d);
      end
    end
  end

  // Strobe and counter next-state.
  always_comb begin
    done_d = wrap;
    cnt_d  = cnt_q;
    if (wrap) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // State registers, synchronous reset with priority over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pulse_q <= 1'b0;
      mode_q  <= ModeRotL;
      pos_q   <= PosZero;
      dir_q   <= DirUp;
      led_q   <= LedReset;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= PULSE_IN;
      mode_q  <= mode_e'(MODE);
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign LED_OUT    = led_q;
  assign CYCLE_DONE = done_q;
  assign CYCLE_CNT  = cnt_q;

endmodule

// File: tb/tb_led_chaser_module.sv
module tb_led_chaser_module;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PULSE_IN = 1'b0;
  logic       EN = 1'b0;
  logic [1:0] MODE = 2'b00;
  logic [3:0] LED_OUT;
  logic       CYCLE_DONE;
  logic [7:0] CYCLE_CNT;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] led;
    logic       done;
    logic [7:0] cnt;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];

  led_chaser_module #(
    .LED_NUM(4),
    .CNT_W  (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PULSE_IN  (PULSE_IN),
    .EN        (EN),
    .MODE      (MODE),
    .LED_OUT   (LED_OUT),
    .CYCLE_DONE(CYCLE_DONE),
    .CYCLE_CNT (CYCLE_CNT)
  );

  always #10 CLK = ~CLK;

  // Drive one clock cycle of inputs; optionally push an expectation and check
  // it 1 time unit after the edge that consumes those inputs.
  task automatic cyc(input logic p, input logic e, input logic [1:0] m, input logic chk,
                     input logic [3:0] el, input logic ed, input logic [7:0] ec,
                     input string tag);
    obs_t  want;
    obs_t  got;
    string t;
    PULSE_IN = p;
    EN       = e;
    MODE     = m;
    if (chk) begin
      exp_q.push_back('{led: el, done: ed, cnt: ec});
      tag_q.push_back(tag);
    end
    @(posedge CLK);
    #1;
    if (chk) begin
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      got  = '{led: LED_OUT, done: CYCLE_DONE, cnt: CYCLE_CNT};
      total++;
      assert (got === want) else begin
        bad++;
        $error("FAIL %s: got led=%b done=%b cnt=%0d, want led=%b done=%b cnt=%0d",
               t, got.led, got.done, got.cnt, want.led, want.done, want.cnt);
      end
    end
  endtask

  // Single-cycle pulse: check the step edge, then check the idle edge after it
  // (LED held, strobe dropped).
  task automatic pulse(input logic [1:0] m, input logic [3:0] el, input logic ed,
                       input logic [7:0] ec, input string tag);
    cyc(1'b1, 1'b1, m, 1'b1, el, ed, ec, tag);
    cyc(1'b0, 1'b1, m, 1'b1, el, 1'b0, ec, {tag, "_idle"});
  endtask

  initial begin
    #1;
    // Reset, with a pulse present to show reset wins.
    RST = 1'b1;
    cyc(1'b1, 1'b1, 2'b00, 1'b0, 4'b0000, 1'b0, 8'd0, "");
    cyc(1'b0, 1'b1, 2'b00, 1'b1, 4'b0001, 1'b0, 8'd0, "reset");
    RST = 1'b0;
    cyc(1'b0, 1'b1, 2'b00, 1'b1, 4'b0001, 1'b0, 8'd0, "post_reset");

    // Rotate-left
    pulse(2'b00, 4'b0010, 1'b0, 8'd0, "rotl1");
    pulse(2'b00, 4'b0100, 1'b0, 8'd0, "rotl2");
    pulse(2'b00, 4'b1000, 1'b0, 8'd0, "rotl3");
    pulse(2'b00, 4'b0001, 1'b1, 8'd1, "rotl4_wrap");

    // Ping-pong
    cyc(1'b0, 1'b1, 2'b10, 1'b1, 4'b0001, 1'b0, 8'd1, "to_ping");
    pulse(2'b10, 4'b0010, 1'b0, 8'd1, "ping1");
    pulse(2'b10, 4'b0100, 1'b0, 8'd1, "ping2");
    pulse(2'b10, 4'b1000, 1'b0, 8'd1, "ping3");
    pulse(2'b10, 4'b0100, 1'b0, 8'd1, "ping4");
    pulse(2'b10, 4'b0010, 1'b0, 8'd1, "ping5");
    pulse(2'b10, 4'b0001, 1'b1, 8'd2, "ping6_done");
    pulse(2'b10, 4'b0010, 1'b0, 8'd2, "ping7");

    // Bar-fill
    cyc(1'b0, 1'b1, 2'b11, 1'b1, 4'b0001, 1'b0, 8'd2, "to_bar");
    pulse(2'b11, 4'b0011, 1'b0, 8'd2, "bar1");
    pulse(2'b11, 4'b0111, 1'b0, 8'd2, "bar2");
    pulse(2'b11, 4'b1111, 1'b0, 8'd2, "bar3");
    pulse(2'b11, 4'b0000, 1'b1, 8'd3, "bar4_blank");
    pulse(2'b11, 4'b0001, 1'b0, 8'd3, "bar5");

    // Long pulse, EN gating, EN rising under a high pulse: one step in total.
    cyc(1'b0, 1'b1, 2'b00, 1'b1, 4'b0001, 1'b0, 8'd3, "to_rotl");
    cyc(1'b1, 1'b1, 2'b00, 1'b1, 4'b0010, 1'b0, 8'd3, "long_first");
    for (int i = 0; i < 19; i++) begin
      cyc(1'b1, 1'b1, 2'b00, 1'b1, 4'b0010, 1'b0, 8'd3, "long_hold");
    end
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 4'b0010, 1'b0, 8'd3, "en0_low");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 2'b00, 1'b1, 4'b0010, 1'b0, 8'd3, "en0_pulse");
      cyc(1'b0, 1'b0, 2'b00, 1'b1, 4'b0010, 1'b0, 8'd3, "en0_gap");
    end
    cyc(1'b1, 1'b0, 2'b00, 1'b1, 4'b0010, 1'b0, 8'd3, "en_rise_pre");
    cyc(1'b1, 1'b1, 2'b00, 1'b1, 4'b0010, 1'b0, 8'd3, "en_rise_no_step");
    cyc(1'b0, 1'b1, 2'b00, 1'b1, 4'b0010, 1'b0, 8'd3, "en_rise_after");

    // Mode change coincident with a pulse rise at pos=2.
    pulse(2'b00, 4'b0100, 1'b0, 8'd3, "pre_chg_pos2");
    cyc(1'b1, 1'b1, 2'b01, 1'b1, 4'b0001, 1'b0, 8'd3, "mode_chg_step_dropped");
    cyc(1'b0, 1'b1, 2'b01, 1'b1, 4'b0001, 1'b0, 8'd3, "mode_chg_hold");
    pulse(2'b01, 4'b1000, 1'b1, 8'd4, "rotr_wrap");
    pulse(2'b01, 4'b0100, 1'b0, 8'd4, "rotr2");

    // Counter wrap: reset, 255 full rotate-left cycles, then one more.
    RST = 1'b1;
    cyc(1'b0, 1'b1, 2'b00, 1'b1, 4'b0001, 1'b0, 8'd0, "reset2");
    RST = 1'b0;
    for (int i = 0; i < 255 * 4; i++) begin
      cyc(1'b1, 1'b1, 2'b00, 1'b0, 4'b0000, 1'b0, 8'd0, "");
      cyc(1'b0, 1'b1, 2'b00, 1'b0, 4'b0000, 1'b0, 8'd0, "");
    end
    cyc(1'b0, 1'b1, 2'b00, 1'b1, 4'b0001, 1'b0, 8'd255, "cnt_255");
    pulse(2'b00, 4'b0010, 1'b0, 8'd255, "wrap1");
    pulse(2'b00, 4'b0100, 1'b0, 8'd255, "wrap2");
    pulse(2'b00, 4'b1000, 1'b0, 8'd255, "wrap3");
    pulse(2'b00, 4'b0001, 1'b1, 8'd0, "cnt_wrap0");

    // Reset mid-pattern with everything else active.
    pulse(2'b00, 4'b0010, 1'b0, 8'd0, "mid1");
    pulse(2'b00, 4'b0100, 1'b0, 8'd0, "mid2");
    pulse(2'b00, 4'b1000, 1'b0, 8'd0, "mid3");
    pulse(2'b00, 4'b0001, 1'b1, 8'd1, "mid4");
    pulse(2'b00, 4'b0010, 1'b0, 8'd1, "mid5");
    RST = 1'b1;
    cyc(1'b1, 1'b0, 2'b11, 1'b1, 4'b0001, 1'b0, 8'd0, "reset_mid");
    RST = 1'b0;
    // mode_q came out of reset as 00, so MODE=00 plus a fresh pulse must step.
    cyc(1'b0, 1'b1, 2'b00, 1'b1, 4'b0001, 1'b0, 8'd0, "post_reset_mid");
    pulse(2'b00, 4'b0010, 1'b0, 8'd0, "post_reset_step");

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
